// File: rtl/arith_seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, valid/ready on both sides.
// Define ARITH_DIV_SIGNED_EN for two's-complement operands (truncate toward zero).
module arith_seq_divider #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shf_q, shf_d;   // dividend bits leave at MSB, quotient bits enter at LSB
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   part_q, part_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   shifted;
    logic [VW+1:0] diff;
    logic          qbit;
    logic [VW:0]   part_next;
    logic [DW-1:0] q_next;
    logic [DW-1:0] acc_dvd;
    logic [VW-1:0] acc_dvs;
    logic [DW-1:0] fin_quo;
    logic [VW-1:0] fin_rem;
    logic          accept;

    assign accept    = (state_q == IDLE) && in_valid;

    assign shifted   = {part_q[VW-1:0], shf_q[DW-1]};
    assign diff      = {1'b0, shifted} - {2'b00, dvs_q};
    assign qbit      = ~diff[VW+1];
    assign part_next = qbit ? diff[VW:0] : shifted;
    assign q_next    = {shf_q[DW-2:0], qbit};

`ifdef ARITH_DIV_SIGNED_EN
    logic negq_q, negr_q;

    // Divide magnitudes; signs are reapplied on the last step.
    assign acc_dvd = dividend[DW-1] ? -dividend : dividend;
    assign acc_dvs = divisor[VW-1]  ? -divisor  : divisor;
    assign fin_quo = negq_q ? -q_next : q_next;
    assign fin_rem = negr_q ? -part_next[VW-1:0] : part_next[VW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (accept) begin
            negq_q <= dividend[DW-1] ^ divisor[VW-1];
            negr_q <= dividend[DW-1];
        end
    end
`else
    assign acc_dvd = dividend;
    assign acc_dvs = divisor;
    assign fin_quo = q_next;
    assign fin_rem = part_next[VW-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shf_d     = shf_q;
        dvs_d     = dvs_q;
        part_d    = part_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shf_d  = acc_dvd;
                    dvs_d  = acc_dvs;
                    part_d = '0;
                    cnt_d  = CW'(DW - 1);
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend[VW-1:0];
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                shf_d  = q_next;
                part_d = part_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    quo_d   = fin_quo;
                    rem_d   = fin_rem;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shf_q   <= '0;
            dvs_q   <= '0;
            part_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shf_q   <= shf_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_arith_seq_divider.sv
// Directed + randomized bench for arith_seq_divider against a plain-arithmetic model.
module tb_arith_seq_divider;

    localparam int DW  = 16;
    localparam int VW  = 8;
    localparam int LAT = DW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    arith_seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division, truncating toward zero in signed mode.
    task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z);
        int sa, sb;
        if (b == '0) begin
            q = '1;
            r = a[VW-1:0];
            z = 1'b1;
        end else begin
`ifdef ARITH_DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = DW'(sa / sb);
            r = VW'(sa % sb);
            z = 1'b0;
        end
    endtask

    task automatic start(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("in_ready_before_start", in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid is seen before an edge.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_accept", out_valid, 0);
        check("in_ready_after_accept", in_ready, 1);
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ez);
        int lat;
        start(a, b);
        wait_result(lat);
        check("latency", lat, (b == '0) ? 1 : LAT);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
        check("in_ready_while_done", in_ready, 0);
        finish_op();
    endtask

    task automatic run_model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic          ez;
        model(a, b, eq, er, ez);
        run_op(a, b, eq, er, ez);
    endtask

    initial begin
        int lat;
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic          ez;
        logic [VW-1:0] ra, rb;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Test-plan directed operations
        run_op(16'h3039, 8'h07, 16'h06E3, 8'h04, 1'b0);
`ifdef ARITH_DIV_SIGNED_EN
        run_op(16'hFF9C, 8'h07, 16'hFFF2, 8'hFE, 1'b0);
        run_op(16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0);
        run_model(16'hFE01, 8'hFF);
`else
        run_op(16'hFE01, 8'hFF, 16'h00FF, 8'h00, 1'b0);
        run_op(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
        run_op(16'h0005, 8'hC8, 16'h0000, 8'h05, 1'b0);
        run_op(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
`endif
        run_op(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1);
        run_model(16'h0000, 8'h05);

        // Back-pressure, plus an operand pulse during CALC that must be ignored
        start(16'h3039, 8'h07);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'hFFFF;
        divisor  = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        check("bp_latency", lat + 2, LAT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_quotient", quotient, 16'h06E3);
            check("bp_remainder", remainder, 8'h04);
            check("bp_dbz", div_by_zero, 0);
        end
        finish_op();

        // Random multiply round-trip sweep
        for (int i = 0; i < 256; i++) begin
            ra = VW'($urandom_range(0, 255));
            rb = VW'($urandom_range(1, 255));
`ifdef ARITH_DIV_SIGNED_EN
            run_model(DW'(ra) * DW'(rb), rb);
`else
            run_op(DW'(ra) * DW'(rb), rb, DW'(ra), '0, 1'b0);
`endif
        end

        // Random operands including zero divisors
        for (int i = 0; i < 40; i++) begin
            ra = VW'($urandom_range(0, 7));
            run_model(DW'($urandom), (ra == 0) ? '0 : VW'($urandom));
        end

        // Asynchronous reset in the middle of a divide
        start(16'h3039, 8'h07);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_quotient", quotient, 0);
        check("mid_rst_remainder", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0);
        model(16'h0064, 8'h0A, eq, er, ez);
        check("post_rst_model_q", quotient, eq);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
